rs232_host: RTL and testbench

//   Bus initiator for the rs232 register interface (data @0, control @1).

---
 rtl/rs232_host.sv | 171 +++++++++++++++++
 tb/tb_rs232_host.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_host.sv
// rs232_host: bus initiator for the rs232 register slave (data @0, control @1).
// Polls the UART for received bytes and delivers them on a valid/ready output
// stream, and drains a valid/ready input stream into the transmitter, so a
// hardware client can use the UART without a CPU. Sole master on the slave port.
//
// Ports:
//   clock, reset_n      clock (rising edge), asynchronous active-low reset
//   address             register select: 0 data, 1 control
//   writeenable         one-cycle write strobe, writedata = {24'd0, byte}
//   readenable          one-cycle read strobe; readdata valid the following cycle
//   tx_data/tx_valid    byte stream to transmit; tx_ready pulses in the write cycle
//   rx_data/rx_valid    received byte stream; rx_valid held until rx_ready
module rs232_host #(
  parameter int unsigned POLL_INTERVAL = 64,
  parameter int unsigned TX_GUARD      = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        address,
  output logic        writeenable,
  output logic [31:0] writedata,
  output logic        readenable,
  input  logic [31:0] readdata,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready
);

  localparam int unsigned PollW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PollW-1:0] PollMax = PollW'(POLL_INTERVAL - 1);
  // TX_GAP spans TX_GUARD-1 cycles after the write cycle (never fewer than one).
  localparam int unsigned GapCycles = (TX_GUARD > 2) ? TX_GUARD - 1 : 1;
  localparam int unsigned GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRxReq,
    StRxWait,
    StTxReq,
    StTxWait,
    StTxWrite,
    StTxGap
  } state_e;

  state_e            state_q, state_d;
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              address_q, address_d;
  logic              writeenable_q, writeenable_d;
  logic              readenable_q, readenable_d;
  logic [31:0]       writedata_q, writedata_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_empty;

  // Only the RVALID, TXSPACE and byte fields of readdata carry meaning.
  logic unused_readdata;
  assign unused_readdata = ^{readdata[31:17], readdata[14:8]};

  // A byte being accepted this cycle frees the buffer in time for a new read.
  assign rx_empty = !rx_valid_q || rx_ready;

  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;

    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d = StTxReq;
        end else if (rx_empty && (poll_cnt_q == PollMax)) begin
          state_d    = StRxReq;
          poll_cnt_d = '0;
        end else if (poll_cnt_q != PollMax) begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      StRxReq: state_d = StRxWait;
      StRxWait: begin
        if (readdata[15]) begin
          rx_data_d  = readdata[7:0];
          rx_valid_d = 1'b1;
          if (tx_valid) begin
            state_d = StTxReq;
          end else begin
            // A data read pops the slave, so the next read must wait for the
            // client to take this byte. Parking in IDLE with a saturated
            // counter re-reads on the very cycle the buffer frees up.
            state_d    = StIdle;
            poll_cnt_d = PollMax;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StTxReq:  state_d = StTxWait;
      StTxWait: state_d = readdata[16] ? StTxWrite : StIdle;
      StTxWrite: begin
        state_d   = StTxGap;
        gap_cnt_d = '0;
      end
      StTxGap: begin
        if (gap_cnt_q == GapLast) begin
          if (rx_empty) begin
            state_d    = StRxReq;
            poll_cnt_d = '0;
          end else begin
            state_d    = StIdle;
            poll_cnt_d = PollMax;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are registered copies of the next-state decode, so they line
  // up with state_q and never glitch.
  always_comb begin
    address_d     = (state_d == StTxReq);
    writeenable_d = (state_d == StTxWrite);
    readenable_d  = (state_d == StRxReq) || (state_d == StTxReq);
    writedata_d   = writeenable_d ? {24'd0, tx_data} : 32'd0;
    tx_ready_d    = writeenable_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      poll_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      rx_data_q     <= 8'd0;
      rx_valid_q    <= 1'b0;
      address_q     <= 1'b0;
      writeenable_q <= 1'b0;
      readenable_q  <= 1'b0;
      writedata_q   <= 32'd0;
      tx_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      poll_cnt_q    <= poll_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      address_q     <= address_d;
      writeenable_q <= writeenable_d;
      readenable_q  <= readenable_d;
      writedata_q   <= writedata_d;
      tx_ready_q    <= tx_ready_d;
    end
  end

  assign address     = address_q;
  assign writeenable = writeenable_q;
  assign readenable  = readenable_q;
  assign writedata   = writedata_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_rs232_host.sv
// Self-checking bench for rs232_host: a behavioural UART slave with a pending
// byte queue and a "busy polls" TX space model, queue scoreboards for both
// streams, per-cycle bus protocol checks, an RX vector table and directed
// plus randomized sequences.
module tb_rs232_host;

  localparam int unsigned PI = 16;
  localparam int unsigned TG = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        address, writeenable, readenable, tx_ready, rx_valid;
  logic [31:0] writedata, readdata;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, rx_ready;

  rs232_host #(.POLL_INTERVAL(PI), .TX_GUARD(TG)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .address    (address),
    .writeenable(writeenable),
    .writedata  (writedata),
    .readenable (readenable),
    .readdata   (readdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model and scoreboards.
  logic [31:0] rx_q[$];      // words the slave returns on data reads
  logic [7:0]  exp_rx[$];    // bytes the client must see, in order
  logic [7:0]  exp_tx[$];    // bytes that must be written, in order
  int busy_polls = 0;        // control reads still to answer "no space"
  int n_data_reads = 0, n_ctrl_reads = 0, n_writes = 0, n_rx_hs = 0;
  int cyc = 0, last_wr = 0;
  bit have_wr = 0, cap_re = 0, cap_addr = 0, prev_re = 0, prev_we = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Bus monitor and stream scoreboard, sampled mid-cycle.
  always @(negedge clock) begin
    cyc++;
    check("we_re_exclusive", 32'(writeenable & readenable), 0);
    check("re_one_cycle", 32'(readenable & prev_re), 0);
    check("we_one_cycle", 32'(writeenable & prev_we), 0);
    if (writeenable) begin
      n_writes++;
      check("wr_addr", 32'(address), 0);
      check("wr_tx_ready", 32'(tx_ready), 1);
      if (have_wr) check("wr_spacing", 32'(cyc - last_wr >= int'(TG)), 1);
      if (exp_tx.size() == 0) fail_now("wr_unexpected");
      else check("wr_data", writedata, {24'd0, exp_tx.pop_front()});
      last_wr = cyc;
      have_wr = 1;
    end else begin
      check("wdata_idle", writedata, 0);
      check("tx_ready_idle", 32'(tx_ready), 0);
    end
    if (readenable && address && have_wr) check("ctrl_guard", 32'(cyc - last_wr >= int'(TG)), 1);
    if (rx_valid && rx_ready) begin
      n_rx_hs++;
      if (exp_rx.size() == 0) fail_now("rx_unexpected");
      else check("rx_order", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
    cap_re   = readenable;
    cap_addr = address;
    prev_re  = readenable;
    prev_we  = writeenable;
  end

  // Slave read data appears the cycle after the strobe; otherwise garbage.
  always @(posedge clock) begin
    logic [31:0] w;
    #1;
    w = $urandom;
    if (cap_re) begin
      if (!cap_addr) begin
        n_data_reads++;
        if (rx_q.size() > 0) w = rx_q.pop_front();
        else w[15] = 1'b0;
      end else begin
        n_ctrl_reads++;
        w[16] = (busy_polls == 0);
        if (busy_polls > 0) busy_polls--;
      end
    end
    readdata = w;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_tx(input logic [7:0] b, input int budget);
    bit got = 0;
    exp_tx.push_back(b);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (tx_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_now("tx_accept_timeout");
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic first_poll(input string name);
    int cnt = 0;
    for (int i = 1; i <= int'(2 * PI + 4); i++) begin
      @(posedge clock);
      #1;
      if (readenable) begin
        cnt = i;
        break;
      end
    end
    check({name, "_cycles"}, 32'(cnt), 32'(PI));
    check({name, "_addr"}, 32'(address), 0);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_rx.size() == 0 && exp_tx.size() == 0 && rx_q.size() == 0) break;
      tick(1);
    end
    check({name, "_rx_left"}, 32'(exp_rx.size()), 0);
    check({name, "_tx_left"}, 32'(exp_tx.size()), 0);
    check({name, "_slave_left"}, 32'(rx_q.size()), 0);
  endtask

  typedef struct {
    logic [31:0] word;
    bit          deliver;
    logic [7:0]  byte_exp;
  } rx_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_vec_t vec[6];
    int w0, c0, d0, h0;
    bit got;

    vec[0] = '{32'h0000_8041, 1'b1, 8'h41};
    vec[1] = '{32'hFFFE_FF5A, 1'b1, 8'h5A};  // junk in ignored bits
    vec[2] = '{32'h0001_7F33, 1'b0, 8'h00};  // RVALID clear: nothing delivered
    vec[3] = '{32'h1234_80C3, 1'b1, 8'hC3};
    vec[4] = '{32'h0000_0000, 1'b0, 8'h00};
    vec[5] = '{32'hAAAA_D500, 1'b1, 8'h00};

    readdata = 32'd0;
    tx_data  = 8'd0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    reset_n  = 1'b0;
    tick(3);
    check("rst_address", 32'(address), 0);
    check("rst_strobes", 32'({writeenable, readenable, tx_ready}), 0);
    check("rst_writedata", writedata, 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    reset_n = 1'b1;
    first_poll("first_poll");

    // RX vector table: rx_ready low, then hold, then accept.
    foreach (vec[k]) begin
      rx_q.push_back(vec[k].word);
      if (vec[k].deliver) exp_rx.push_back(vec[k].byte_exp);
      for (int i = 0; i < int'(3 * PI + 10); i++) begin
        if (rx_q.size() == 0) break;
        tick(1);
      end
      tick(3);
      check("vec_rx_valid", 32'(rx_valid), 32'(vec[k].deliver));
      if (vec[k].deliver) begin
        check("vec_rx_data", 32'(rx_data), 32'(vec[k].byte_exp));
        d0 = n_data_reads;
        tick(10);
        check("vec_hold_valid", 32'(rx_valid), 1);
        check("vec_hold_data", 32'(rx_data), 32'(vec[k].byte_exp));
        check("vec_no_read_while_full", 32'(n_data_reads - d0), 0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
        check("vec_rx_cleared", 32'(rx_valid), 0);
      end
    end

    // Single transmit with space available.
    w0 = n_writes;
    send_tx(8'h55, 60);
    @(negedge clock);
    check("tx_ready_one_cycle", 32'(tx_ready), 0);
    tick(1);
    check("tx_single_write", 32'(n_writes - w0), 1);

    // Transmitter busy for five control polls.
    busy_polls = 5;
    w0 = n_writes;
    c0 = n_ctrl_reads;
    send_tx(8'hA7, 200);
    tick(1);
    check("tx_busy_writes", 32'(n_writes - w0), 1);
    check("tx_busy_ctrl_reads", 32'(n_ctrl_reads - c0), 6);

    // Reset in TX_WAIT with a byte parked in the rx buffer.
    rx_q.push_back(32'h0000_8077);
    exp_rx.push_back(8'h77);
    got = 0;
    for (int i = 0; i < int'(3 * PI + 10); i++) begin
      tick(1);
      if (rx_valid) begin
        got = 1;
        break;
      end
    end
    check("mid_rst_rx_parked", 32'(got), 1);
    busy_polls = 1000;
    w0 = n_writes;
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (readenable && address) begin
        got = 1;
        break;
      end
    end
    check("mid_rst_ctrl_read_seen", 32'(got), 1);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_strobes", 32'({address, writeenable, readenable, tx_ready}), 0);
    check("mid_rst_rx_valid", 32'(rx_valid), 0);
    check("mid_rst_rx_data", 32'(rx_data), 0);
    check("mid_rst_writedata", writedata, 0);
    exp_rx.delete();
    tx_valid   = 1'b0;
    busy_polls = 0;
    tick(2);
    reset_n = 1'b1;
    first_poll("mid_rst_first_poll");
    check("mid_rst_no_write", 32'(n_writes - w0), 0);

    // RX burst with continuous TX traffic and an always-ready client.
    rx_ready = 1'b1;
    h0 = n_rx_hs;
    w0 = n_writes;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = 8'h31 + 8'(i);
      rx_q.push_back({16'h0000, 8'h80, b});
      exp_rx.push_back(b);
    end
    for (int i = 0; i < 4; i++) send_tx(8'hB1 + 8'(i), 100);
    drain("burst", 500);
    check("burst_rx_count", 32'(n_rx_hs - h0), 3);
    check("burst_tx_count", 32'(n_writes - w0), 4);

    // Randomized traffic on both streams.
    h0 = n_rx_hs;
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          if ($urandom_range(0, 19) == 0 && rx_q.size() < 4) begin
            logic [31:0] wd;
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) begin
              wd[15] = 1'b0;
            end else begin
              wd[15] = 1'b1;
              exp_rx.push_back(wd[7:0]);
            end
            rx_q.push_back(wd);
          end
          tick(1);
        end
      end
      begin
        for (int i = 0; i < 80; i++) begin
          tick($urandom_range(1, 8));
          if ($urandom_range(0, 3) == 0) busy_polls = $urandom_range(0, 3);
          send_tx(8'($urandom), 400);
        end
      end
      begin
        for (int i = 0; i < 3000; i++) begin
          rx_ready = ($urandom_range(0, 2) != 0);
          tick(1);
        end
      end
    join
    rx_ready = 1'b1;
    drain("random", 2000);
    check("random_rx_seen", 32'(n_rx_hs - h0 > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
